// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: access-size encodings shared with riscv_memory and the LSU FSM state encoding.
package riscv_mem_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ERR} lsu_state_e;
endpackage

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: core request/response handshake plus the riscv_memory data port seen by the LSU.
interface riscv_lsu_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] daddr_o;
    logic [31:0] dwdata_o;
    logic [1:0]  dsize_o;
    logic        drd_o;
    logic        dwr_o;
    logic [31:0] drdata_i;
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, drdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, daddr_o, dwdata_o, dsize_o, drd_o, dwr_o
    );
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, drdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, daddr_o, dwdata_o, dsize_o, drd_o, dwr_o
    );
endinterface

// File: rtl/riscv_lsu_load_align.sv
// riscv_lsu_load_align: picks the addressed byte/half out of the memory word and sign/zero-extends it.
module riscv_lsu_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] drdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o
);
    logic [15:0] lane;
    assign lane = 16'(drdata_i >> {offset_i, 3'b000});
    assign rdata_o = size_i == SIZE_BYTE ? {{24{~unsigned_i & lane[7]}}, lane[7:0]} :
                     size_i == SIZE_HALF ? {{16{~unsigned_i & lane[15]}}, lane} : drdata_i;
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: one-at-a-time load/store unit driving the riscv_memory data port.
// Define RISCV_LSU_ALIGN_CHECK_EN to fault misaligned/illegal requests instead of silently aligning them.
module riscv_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic        clk_i,
    input logic        reset_i,
    riscv_lsu_if.slave bus
);
    lsu_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d, uns_q, uns_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic [31:0] daddr_q, daddr_d, dwdata_q, dwdata_d, rdata_q, rdata_d;
    logic [1:0]  dsize_q, dsize_d;
    logic [1:0]  size_n;
    logic [31:0] addr_n, wdata_r, load_data;
`ifdef RISCV_LSU_ALIGN_CHECK_EN
    logic bad;
    assign size_n = bus.req_size_i;
    assign addr_n = bus.req_addr_i;
    assign bad = (bus.req_size_i == 2'd3) | (bus.req_size_i == SIZE_HALF & bus.req_addr_i[0]) |
                 (bus.req_size_i == SIZE_WORD & |bus.req_addr_i[1:0]);
`else
    // Without fault checking, size 3 is a word and offending low address bits are dropped.
    assign size_n = bus.req_size_i == 2'd3 ? SIZE_WORD : bus.req_size_i;
    assign addr_n = size_n == SIZE_WORD ? {bus.req_addr_i[31:2], 2'b00} :
                    size_n == SIZE_HALF ? {bus.req_addr_i[31:1], 1'b0} : bus.req_addr_i;
`endif
    assign wdata_r = size_n == SIZE_BYTE ? {4{bus.req_wdata_i[7:0]}} :
                     size_n == SIZE_HALF ? {2{bus.req_wdata_i[15:0]}} : bus.req_wdata_i;
    riscv_lsu_load_align u_align (
        .drdata_i  (bus.drdata_i),
        .offset_i  (daddr_q[1:0]),
        .size_i    (dsize_q),
        .unsigned_i(uns_q),
        .rdata_o   (load_data)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        uns_d    = uns_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dsize_d  = dsize_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid_i) begin
                we_d  = bus.req_we_i;
                uns_d = bus.req_unsigned_i;
`ifdef RISCV_LSU_ALIGN_CHECK_EN
                if (bad) state_d = ERR;
                else
`endif
                begin
                    state_d  = ACCESS;
                    daddr_d  = addr_n;
                    dwdata_d = wdata_r;
                    dsize_d  = size_n;
                end
            end
            ACCESS: begin
                state_d = we_q ? IDLE : WAIT;
                cnt_d   = 3'(MEM_LATENCY - 1);
                valid_d = we_q;
                rdata_d = we_q ? '0 : rdata_q;
            end
            WAIT: begin
                state_d = cnt_q == 3'd0 ? IDLE : WAIT;
                cnt_d   = cnt_q == 3'd0 ? cnt_q : cnt_q - 3'd1;
                valid_d = cnt_q == 3'd0;
                rdata_d = cnt_q == 3'd0 ? load_data : rdata_q;
            end
`ifdef RISCV_LSU_ALIGN_CHECK_EN
            ERR: begin
                state_d = IDLE;
                valid_d = 1'b1;
                err_d   = 1'b1;
                rdata_d = '0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dsize_q  <= SIZE_WORD;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            uns_q    <= uns_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dsize_q  <= dsize_d;
            rdata_q  <= rdata_d;
        end
    end
    assign bus.req_ready_o = state_q == IDLE;
    assign bus.drd_o       = state_q == ACCESS & ~we_q;
    assign bus.dwr_o       = state_q == ACCESS & we_q;
    assign bus.rsp_valid_o = valid_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.daddr_o     = daddr_q;
    assign bus.dwdata_o    = dwdata_q;
    assign bus.dsize_o     = dsize_q;
endmodule
